// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store bridge: access sizes, FSM states, word width.
package lsu_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WRITE,
    RESP
  } state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge, little-endian.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [WORD_W-1:0] i_word,
  input  logic [1:0]        i_size,
  input  logic [1:0]        i_lane,
  input  logic              i_unsigned,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_load,
  output logic [WORD_W-1:0] o_merge
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    unique case (i_lane)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    // Half lane is addr[1]; addr[0] never steers the lane.
    w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_load  = i_word;
    o_merge = i_wdata;
    unique case (i_size)
      SIZE_BYTE: begin
        o_load = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
        unique case (i_lane)
          2'd0: o_merge = {i_word[31:8], i_wdata[7:0]};
          2'd1: o_merge = {i_word[31:16], i_wdata[7:0], i_word[7:0]};
          2'd2: o_merge = {i_word[31:24], i_wdata[7:0], i_word[15:0]};
          2'd3: o_merge = {i_wdata[7:0], i_word[23:0]};
          default: o_merge = i_word;
        endcase
      end
      SIZE_HALF: begin
        o_load  = {{16{w_half[15] & ~i_unsigned}}, w_half};
        o_merge = i_lane[1] ? {i_wdata[15:0], i_word[15:0]} : {i_word[31:16], i_wdata[15:0]};
      end
      default: begin
        o_load  = i_word;
        o_merge = i_wdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_bridge.sv
// Byte/half/word load-store bridge onto a word-wide memory; sub-word stores use read-modify-write.
// Build option: define LSU_ALIGN_CHECK_EN to reject misaligned half/word requests.
module lsu_mem_bridge
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 16384
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [WORD_W-1:0] mem_address,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              mem_we
);

  state_e r_state, w_state_next;

  logic [WORD_W-1:0] r_addr, r_wdata, r_merge, r_rdata;
  logic [1:0]        r_size;
  logic              r_we, r_unsigned, r_err;
  logic              w_accept, w_illegal, w_misaligned;
  logic [WORD_W-1:0] w_load, w_merge;

  assign w_accept = (r_state == IDLE) && req_valid;

`ifdef LSU_ALIGN_CHECK_EN
  assign w_misaligned = ((req_size == SIZE_HALF) && req_addr[0]) ||
                        ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_illegal = (req_size == 2'b11) || (req_addr >= MEM_BYTES) || w_misaligned;

  lsu_lane_align u_lane_align (
    .i_word     (mem_rdata),
    .i_size     (r_size),
    .i_lane     (r_addr[1:0]),
    .i_unsigned (r_unsigned),
    .i_wdata    (r_wdata),
    .o_load     (w_load),
    .o_merge    (w_merge)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (req_valid) w_state_next = w_illegal ? RESP : ACCESS;
      ACCESS:  w_state_next = (r_we && (r_size != SIZE_WORD)) ? WRITE : RESP;
      WRITE:   w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == IDLE);
    rsp_valid = (r_state == RESP);
    rsp_err   = (r_state == RESP) && r_err;
    mem_we    = 1'b0;
    mem_wdata = '0;
    unique case (r_state)
      ACCESS: begin
        if (r_we && (r_size == SIZE_WORD)) begin
          mem_we    = !reset;
          mem_wdata = r_wdata;
        end
      end
      WRITE: begin
        mem_we    = !reset;
        mem_wdata = r_merge;
      end
      default: begin
        mem_we    = 1'b0;
        mem_wdata = '0;
      end
    endcase
  end

  assign mem_address = {r_addr[WORD_W-1:2], 2'b00};
  assign rsp_rdata   = r_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_merge    <= '0;
      r_rdata    <= '0;
      r_size     <= SIZE_BYTE;
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
        r_size     <= req_size;
        r_we       <= req_we;
        r_unsigned <= req_unsigned;
        r_err      <= w_illegal;
        r_rdata    <= '0;
      end
      if (r_state == ACCESS) begin
        if (!r_we) begin
          r_rdata <= w_load;
        end else begin
          r_merge <= w_merge;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Randomised bench for lsu_mem_bridge against a byte-arithmetic reference memory model.
module tb_lsu_mem_bridge;

  localparam int unsigned MEM_BYTES = 16384;
  localparam int unsigned WORDS     = MEM_BYTES / 4;

`ifdef LSU_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err, mem_we;
  logic [31:0] rsp_rdata, mem_address, mem_wdata, mem_rdata;

  logic [31:0] mem     [WORDS] = '{default: '0};
  logic [31:0] ref_mem [WORDS] = '{default: '0};

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lsu_mem_bridge #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_we       (mem_we)
  );

  // Memory behind the bridge: combinational read, synchronous word write.
  assign mem_rdata = mem[mem_address[13:2]];
  always @(posedge clk) if (mem_we) mem[mem_address[13:2]] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge while the bridge is idle; returns at a negedge.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int          lat, we_cnt, we_at, exp_lat, exp_we_cnt, exp_we_at;
    int unsigned nbytes, off;
    logic [31:0] we_data, got_rdata, exp_rdata, exp_wdata, mask, old, val;
    logic        got_err, exp_err, illegal;
    int          widx;

    // Reference model: expectation from address/size rules and plain arithmetic.
    widx    = int'(addr[13:2]);
    old     = ref_mem[widx];
    illegal = (size == 2'b11) || (addr >= MEM_BYTES) ||
              (ALIGN && (((size == 2'b01) && addr[0]) || ((size == 2'b10) && (addr[1:0] != 0))));
    exp_err = 1'b0; exp_rdata = '0; exp_wdata = '0; exp_we_cnt = 0; exp_we_at = 0;
    if (illegal) begin
      exp_lat = 1;
      exp_err = 1'b1;
    end else begin
      nbytes = 1 << size;
      off    = (size == 2'b00) ? addr[1:0] : (size == 2'b01) ? {addr[1], 1'b0} : 0;
      mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 1);
      if (!we) begin
        exp_lat = 2;
        val = (old >> (8 * off)) & mask;
        if (!uns && (nbytes < 4) && (((val >> (8 * nbytes - 1)) & 1) == 1)) val = val | ~mask;
        exp_rdata = val;
      end else begin
        exp_wdata     = (old & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
        ref_mem[widx] = exp_wdata;
        exp_lat       = (nbytes == 4) ? 2 : 3;
        exp_we_cnt    = 1;
        exp_we_at     = exp_lat - 1;
      end
    end

    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    lat = 0; we_cnt = 0; we_at = 0; we_data = '0; got_rdata = '0; got_err = 1'b0;
    for (int k = 1; k <= 6 && lat == 0; k++) begin
      @(negedge clk);
      if (mem_we) begin
        we_cnt++;
        if (we_at == 0) begin
          we_at   = k;
          we_data = mem_wdata;
        end
      end
      if (rsp_valid) begin
        lat       = k;
        got_rdata = rsp_rdata;
        got_err   = rsp_err;
      end
      req_valid = 1'b0;
    end
    check("rsp_latency", lat, exp_lat);
    check("rsp_err", {31'd0, got_err}, {31'd0, exp_err});
    check("rsp_rdata", got_rdata, exp_rdata);
    check("mem_we_count", we_cnt, exp_we_cnt);
    if (exp_we_cnt != 0) begin
      check("mem_we_cycle", we_at, exp_we_at);
      check("mem_wdata", we_data, exp_wdata);
    end
    @(negedge clk);
    check("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int nbad;
    logic [31:0] a;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    reset = 1'b0;
    @(negedge clk);

    do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'h1122_3344);
    do_req(1'b1, 2'b00, 1'b0, 32'h102, 32'h0000_00AB);
    check("rmw_word_0x100", mem[64], 32'h11AB_3344);
    do_req(1'b1, 2'b10, 1'b0, 32'h200, 32'h0000_F080);
    do_req(1'b0, 2'b00, 1'b0, 32'h200, 32'h0);
    do_req(1'b0, 2'b00, 1'b1, 32'h200, 32'h0);
    do_req(1'b0, 2'b01, 1'b0, 32'h200, 32'h0);
    do_req(1'b0, 2'b01, 1'b1, 32'h203, 32'h0);
    do_req(1'b1, 2'b11, 1'b0, 32'h100, 32'h1234_5678);
    do_req(1'b0, 2'b10, 1'b0, 32'h4000, 32'h0);
    do_req(1'b1, 2'b00, 1'b0, 32'h3FFF, 32'h0000_005A);
    do_req(1'b0, 2'b00, 1'b1, 32'h3FFF, 32'h0);
    do_req(1'b0, 2'b10, 1'b0, 32'h102, 32'h0);
    do_req(1'b1, 2'b01, 1'b0, 32'h101, 32'h0000_C3D4);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0) a = 32'h4000 + $urandom_range(0, 32'hFFFF);
      else a = $urandom_range(0, 32'h3FF);
      do_req(1'(($urandom_range(0, 1))), 2'($urandom_range(0, 3)),
             1'(($urandom_range(0, 1))), a, $urandom);
    end

    // Reset landing on the WRITE cycle of a half store must suppress the write.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h300; req_wdata = 32'h0000_A5A5;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_write_we", {31'd0, mem_we}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_write_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    check("rst_write_rsp", {31'd0, rsp_valid}, 32'd0);
    check("rst_write_we2", {31'd0, mem_we}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    check("post_rst_rsp", {31'd0, rsp_valid}, 32'd0);
    check("post_rst_mem", mem[32'h300 >> 2], ref_mem[32'h300 >> 2]);

    nbad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nbad++;
    if (mem[WORDS-1] !== ref_mem[WORDS-1]) nbad++;
    check("mem_sweep_bad_words", nbad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu_mem_bridge.md
Name: lsu_mem_bridge

Overview:
- Load/store bridge directly upstream of the word-wide data memory (combinational read; synchronous, word-only write).
- Accepts byte/half/word load and store requests from the core's memory stage and produces them as word accesses.
- Sub-word stores become read-modify-write sequences; loads are lane-extracted and sign/zero-extended.
- Single outstanding request; one-cycle response pulse.

Parameters:
- MEM_BYTES, 16384, addressable memory size in bytes; byte addresses >= MEM_BYTES are out of range.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  bridge idle, accepts request this cycle
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extend when 1, sign-extend when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  1  request rejected, no memory write performed
- mem_address  out  32  word-aligned address to memory ({addr[31:2],2'b00})
- mem_wdata  out  32  write data to memory
- mem_rdata  in  32  read data from memory (combinational, same cycle)
- mem_we  out  1  memory write enable

Behaviour:
- States: IDLE, ACCESS, WRITE, RESP.
- Reset values: state IDLE; rsp_valid, rsp_err and mem_we are 0; rsp_rdata, mem_address and mem_wdata are 0.
- IDLE:
  - req_ready=1.
  - req_valid=1 latches addr, size, we, unsigned and wdata.
  - Illegal request (size 11, addr >= MEM_BYTES, or misaligned per Optional Feature) -> RESP with err set.
  - Legal request -> ACCESS.
- ACCESS:
  - mem_address driven; mem_rdata sampled this cycle.
  - Load: extracted and extended lane registered into rsp_rdata -> RESP.
  - Word store: mem_we=1, mem_wdata=wdata -> RESP.
  - Byte/half store: merged word (mem_rdata with the addressed lane replaced by wdata[7:0] or wdata[15:0]) registered -> WRITE.
- WRITE: mem_we=1, mem_wdata=merge register, mem_address held -> RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle -> IDLE.
  - No response backpressure.
  - req_ready=0 in every state except IDLE.
- Latency, counted with the accept cycle as T:
  - Load and word store: rsp_valid at T+2.
  - Sub-word store: rsp_valid at T+3.
  - Error: rsp_valid at T+1.
- Lane selection, little-endian:
  - Byte lane = addr[1:0].
  - Half lane = addr[1]; addr[0] is checked or ignored per the Optional Feature.
  - Word accesses ignore addr[1:0] unless the Optional Feature is enabled.
- Extension: byte uses bit 7, half uses bit 15; sign-extend or zero-extend per req_unsigned.
- mem_we is gated by !reset. If reset is asserted in ACCESS or WRITE, no write occurs and the state returns to IDLE the next cycle; the request is dropped with no response.
- A request arriving while req_ready=0 is ignored; the requester holds it until it sees ready.

Optional Feature:
- Macro: LSU_ALIGN_CHECK_EN.
- Defined:
  - Half with addr[0]=1 is misaligned; word with addr[1:0]!=0 is misaligned.
  - Misaligned requests respond at T+1 with rsp_err=1 and rsp_rdata=0, with no memory access.
- Undefined:
  - Low address bits below the access size are ignored.
  - The access is aligned down and completes normally.

Decomposition:
- Shared package lsu_pkg:
  - size encodings SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10;
  - state enum IDLE/ACCESS/WRITE/RESP;
  - word width constant 32.
- Sub-module lsu_lane_align, purely combinational:
  - load path: extract and extend from word, size, lane and unsigned flag;
  - store path: merge store data into the old word.
- The FSM and registers remain in lsu_mem_bridge.

Test Plan:
- Word store then load:
  - store 0xDEADBEEF to 0x100 -> mem_we at T+1, rsp_valid at T+2.
  - load word 0x100 -> rsp_rdata=0xDEADBEEF at T+2.
- Byte store RMW: memory word 0x100 = 0x11223344; store byte 0xAB to 0x102 -> mem_we at T+2 with mem_wdata=0x11AB3344, rsp_valid at T+3.
- Sign and zero extension, word 0x200 = 0x0000F080:
  - signed byte load at 0x200 -> 0xFFFFFF80;
  - unsigned byte load at 0x200 -> 0x00000080;
  - signed half load at 0x200 -> 0xFFFFF080.
- Errors:
  - size 11 -> rsp_err=1 at T+1, mem_we never asserted;
  - addr 0x4000 with MEM_BYTES=16384 -> rsp_err=1.
- Misaligned word load at 0x102:
  - with LSU_ALIGN_CHECK_EN -> rsp_err=1 at T+1;
  - without -> reads word 0x100, err=0 at T+2.
- Reset during WRITE of a half store -> mem_we stays 0, no rsp_valid, req_ready=1 in the cycle after reset deasserts, memory unchanged.
